filterbank_sequencer: RTL and testbench
=======================================

# filterbank_sequencer

Control sequencer for the 8-channel FIR filter bank datapath. On each input sample strobe it writes the sample into a circular sample memory, then walks the shared coefficient address bus and the sample read address over all taps. It drives the MAC control strobes and raises a single output-load strobe when all eight accumulators hold a finished result. It sits between the sample source (`din_enable`) and the coefficient ROMs, sample RAM and eight MAC lanes.

## Interface
Parameters:
- `NTAPS`, 64: taps per filter; must be a power of two.
- `ADDR_W`, 6: address width; must equal log2(NTAPS).
- `MAC_LAT`, 2: cycles from read address to operands valid at the MAC (memory read plus multiplier register).

Ports:
- `clock`  in  1  master clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `din_enable`  in  1  new-sample strobe, one cycle wide.
- `wr_enable`  out  1  sample-RAM write enable.
- `wr_zero`  out  1  selects zero as sample-RAM write data (INIT only).
- `wr_address`  out  ADDR_W  sample-RAM write address.
- `coeffaddress`  out  ADDR_W  shared coefficient-ROM read address.
- `sampleaddress`  out  ADDR_W  sample-RAM read address.
- `mac_enable`  out  1  accumulate the current product.
- `mac_clear`  out  1  with `mac_enable`: load the product instead of accumulating.
- `mac_last`  out  1  marks the final accumulate of a sample.
- `dout_load`  out  1  one-cycle strobe: latch all eight accumulators to `dataout0..7`.
- `busy`  out  1  high in any state other than IDLE.
- `overrun`  out  1  sticky; a `din_enable` was ignored.

## Operation
- All outputs are registered.
- States: INIT, IDLE, WRITE, RUN, DRAIN, LOAD.
- Internal registers: `head` (ADDR_W, next write slot), `cur` (slot of the current sample), tap counter `i`, and a MAC_LAT-deep valid pipeline.
- INIT:
  - Entered on reset release.
  - For NTAPS cycles: `wr_enable`=1, `wr_zero`=1, `wr_address`=0..NTAPS-1.
  - Then go to IDLE.
- IDLE: `din_enable`=1 sets `cur`←`head` and moves to WRITE.
- WRITE, one cycle:
  - `wr_enable`=1, `wr_zero`=0, `wr_address`=`cur`.
  - `head`←`head`+1, modulo NTAPS with natural wrap.
  - Move to RUN.
- RUN, NTAPS cycles, i=0..NTAPS-1:
  - `coeffaddress`=i.
  - `sampleaddress`=(`cur`−i) mod NTAPS, so the newest sample pairs with coefficient 0.
  - The internal read-valid bit is 1 in every RUN cycle.
- DRAIN: held until the valid pipeline empties.
- MAC strobes:
  - `mac_enable` is the read-valid bit delayed by MAC_LAT.
  - `mac_clear` coincides with the first `mac_enable` of a sample.
  - `mac_last` coincides with the last `mac_enable` of a sample.
- LOAD, one cycle: `dout_load`=1, then return to IDLE.
- Address outputs hold their last value outside the active state; the datapath must not depend on them then.
- Overrun rule:
  - `din_enable` is accepted only in IDLE.
  - In INIT, WRITE, RUN, DRAIN or LOAD it is ignored and `overrun` is set.
  - `overrun` is cleared only by reset.
- Reset assertion, any state:
  - All outputs go to 0 immediately, `head`=0, state=INIT.
  - No `dout_load` is issued for the aborted sample.
  - Sample-RAM contents are overwritten by the next INIT.

## Timing
- Cycle 1 is the first cycle after the edge that samples `din_enable`=1 in IDLE.
- Per-sample schedule:
  - WRITE in cycle 1.
  - RUN in cycles 2..NTAPS+1.
  - `mac_enable` in cycles 2+MAC_LAT..NTAPS+1+MAC_LAT.
  - `dout_load` in cycle NTAPS+MAC_LAT+2.
- `busy`=1 in cycles 1..NTAPS+MAC_LAT+2. With defaults that is cycles 1..68, with `dout_load` in cycle 68.
- Minimum sample period is NTAPS+MAC_LAT+3 cycles (69 with defaults).
  - `din_enable` in cycle 69 is accepted with no overrun.
  - `din_enable` in cycle 68 (LOAD) is an overrun.
- INIT lasts NTAPS cycles after reset release; `busy`=1 throughout.
- Reset values of every output: 0.

## Test plan
- Reset release:
  - Stimulus: release `reset`.
  - Required: cycles 1..64 show `wr_enable`=1, `wr_zero`=1, `wr_address`=0..63, `busy`=1.
  - Then IDLE with `busy`=0 and all other outputs 0.
- Single sample with `head`=0:
  - Cycle 1: `wr_address`=0.
  - Cycles 2..65: `coeffaddress`=0..63 and `sampleaddress`=0,63,62..1.
  - Cycle 4: `mac_clear`=1. Cycle 67: `mac_last`=1. Cycle 68: `dout_load`=1.
  - Afterwards `head`=1.
- Wrap-around:
  - Stimulus: after 69 samples, `cur`=5.
  - Required: `sampleaddress` sequence 5,4..0,63..6, and `head`→6.
  - Stimulus: sample at `cur`=63.
  - Required: `head` wraps to 0.
- Overrun:
  - Stimulus: `din_enable` in cycle 30 of a sample.
  - Required: `overrun`=1 from the next cycle; schedule unchanged (`dout_load` still in cycle 68; `head` unchanged).
  - Stimulus: `din_enable` in cycle 68.
  - Required: `overrun`=1.
- Back-to-back samples:
  - Stimulus: `din_enable` in cycle 69.
  - Required: accepted, next WRITE in cycle 70, `overrun` stays 0.
- Reset mid-RUN:
  - Stimulus: assert `reset` in cycle 40.
  - Required: all outputs 0 asynchronously, no `dout_load`, and INIT repeats after release with `head`=0.

Source files
------------

// File: rtl/filterbank_sequencer.sv
// Control sequencer for an 8-lane FIR filter bank: zero-fills the sample RAM,
// then per input sample writes it and walks all taps, issuing MAC and load strobes.
module filterbank_sequencer #(
    parameter int NTAPS   = 64,
    parameter int ADDR_W  = 6,
    parameter int MAC_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              din_enable,
    output logic              wr_enable,
    output logic              wr_zero,
    output logic [ADDR_W-1:0] wr_address,
    output logic [ADDR_W-1:0] coeffaddress,
    output logic [ADDR_W-1:0] sampleaddress,
    output logic              mac_enable,
    output logic              mac_clear,
    output logic              mac_last,
    output logic              dout_load,
    output logic              busy,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0]  LAST_TAP  = ADDR_W'(NTAPS - 1);
    localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [MAC_LAT-1:0] PIPE_IDLE = {MAC_LAT{1'b0}};

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_LOAD  = 3'd5
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_head, w_head_nxt;
    logic [ADDR_W-1:0] r_cur, w_cur_nxt;
    logic [ADDR_W-1:0] r_tap, w_tap_nxt, w_tap_inc;
    logic [ADDR_W-1:0] r_wr_address, w_wr_address_nxt;
    logic [ADDR_W-1:0] r_coeffaddress, w_coeff_nxt;
    logic [ADDR_W-1:0] r_sampleaddress, w_sample_nxt;
    logic              w_rd_valid, w_rd_first, w_rd_last;
    // Bit 0 is the read stage; bit MAC_LAT lines up with operands at the MAC.
    logic [MAC_LAT:0]  r_vpipe, r_fpipe, r_lpipe;
    logic              r_wr_enable, r_wr_zero, r_dout_load, r_busy, r_overrun;

    assign w_tap_inc = r_tap + ADDR_ONE;

    // Next-state and next-address logic; outputs are registered from the entered state.
    always_comb begin
        w_state_nxt      = r_state;
        w_head_nxt       = r_head;
        w_cur_nxt        = r_cur;
        w_tap_nxt        = r_tap;
        w_wr_address_nxt = r_wr_address;
        w_coeff_nxt      = r_coeffaddress;
        w_sample_nxt     = r_sampleaddress;
        w_rd_valid       = 1'b0;
        w_rd_first       = 1'b0;
        w_rd_last        = 1'b0;
        case (r_state)
            ST_INIT: begin
                // wr_enable low means the clear sweep has not started yet.
                if (r_wr_enable && (r_wr_address == LAST_TAP)) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wr_enable) begin
                    w_wr_address_nxt = r_wr_address + ADDR_ONE;
                end else begin
                    w_wr_address_nxt = ADDR_ZERO;
                end
            end
            ST_IDLE: begin
                if (din_enable) begin
                    w_state_nxt      = ST_WRITE;
                    w_cur_nxt        = r_head;
                    w_wr_address_nxt = r_head;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WRITE: begin
                w_state_nxt  = ST_RUN;
                w_head_nxt   = r_head + ADDR_ONE;
                w_tap_nxt    = ADDR_ZERO;
                w_coeff_nxt  = ADDR_ZERO;
                w_sample_nxt = r_cur;
                w_rd_valid   = 1'b1;
                w_rd_first   = 1'b1;
            end
            ST_RUN: begin
                if (r_tap == LAST_TAP) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_tap_nxt    = w_tap_inc;
                    w_coeff_nxt  = w_tap_inc;
                    w_sample_nxt = r_cur - w_tap_inc;
                    w_rd_valid   = 1'b1;
                    w_rd_last    = (w_tap_inc == LAST_TAP);
                end
            end
            ST_DRAIN: begin
                if (r_vpipe[MAC_LAT-1:0] == PIPE_IDLE) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // State, sample pointers and address registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_INIT;
            r_head          <= ADDR_ZERO;
            r_cur           <= ADDR_ZERO;
            r_tap           <= ADDR_ZERO;
            r_wr_address    <= ADDR_ZERO;
            r_coeffaddress  <= ADDR_ZERO;
            r_sampleaddress <= ADDR_ZERO;
        end else begin
            r_state         <= w_state_nxt;
            r_head          <= w_head_nxt;
            r_cur           <= w_cur_nxt;
            r_tap           <= w_tap_nxt;
            r_wr_address    <= w_wr_address_nxt;
            r_coeffaddress  <= w_coeff_nxt;
            r_sampleaddress <= w_sample_nxt;
        end
    end

    // Strobe registers, MAC valid/first/last pipelines and the sticky overrun flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_enable <= 1'b0;
            r_wr_zero   <= 1'b0;
            r_dout_load <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_vpipe     <= {(MAC_LAT + 1){1'b0}};
            r_fpipe     <= {(MAC_LAT + 1){1'b0}};
            r_lpipe     <= {(MAC_LAT + 1){1'b0}};
        end else begin
            r_wr_enable <= (w_state_nxt == ST_INIT) || (w_state_nxt == ST_WRITE);
            r_wr_zero   <= (w_state_nxt == ST_INIT);
            r_dout_load <= (w_state_nxt == ST_LOAD);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_overrun   <= r_overrun | (din_enable & (r_state != ST_IDLE));
            r_vpipe     <= {r_vpipe[MAC_LAT-1:0], w_rd_valid};
            r_fpipe     <= {r_fpipe[MAC_LAT-1:0], w_rd_first};
            r_lpipe     <= {r_lpipe[MAC_LAT-1:0], w_rd_last};
        end
    end

    assign wr_enable     = r_wr_enable;
    assign wr_zero       = r_wr_zero;
    assign wr_address    = r_wr_address;
    assign coeffaddress  = r_coeffaddress;
    assign sampleaddress = r_sampleaddress;
    assign mac_enable    = r_vpipe[MAC_LAT];
    assign mac_clear     = r_fpipe[MAC_LAT];
    assign mac_last      = r_lpipe[MAC_LAT];
    assign dout_load     = r_dout_load;
    assign busy          = r_busy;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_filterbank_sequencer.sv
// Self-checking bench for filterbank_sequencer: per-cycle expectations are
// derived from the per-sample schedule formulas and a small head/overrun model.
module tb_filterbank_sequencer;

    localparam int NT   = 64;
    localparam int AW   = 6;
    localparam int LAT  = 2;
    localparam int SPAN = NT + LAT + 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          din_enable = 1'b0;
    logic          wr_enable, wr_zero, mac_enable, mac_clear, mac_last;
    logic          dout_load, busy, overrun;
    logic [AW-1:0] wr_address, coeffaddress, sampleaddress;

    int errors = 0;
    int checks = 0;

    int m_head        = 0;
    int m_ov          = 0;
    int m_coeff_hold  = 0;
    int m_sample_hold = 0;

    filterbank_sequencer #(.NTAPS(NT), .ADDR_W(AW), .MAC_LAT(LAT)) dut (
        .clock        (clock),
        .reset        (reset),
        .din_enable   (din_enable),
        .wr_enable    (wr_enable),
        .wr_zero      (wr_zero),
        .wr_address   (wr_address),
        .coeffaddress (coeffaddress),
        .sampleaddress(sampleaddress),
        .mac_enable   (mac_enable),
        .mac_clear    (mac_clear),
        .mac_last     (mac_last),
        .dout_load    (dout_load),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int wrap(input int v);
        return ((v % NT) + NT) % NT;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " wr_enable"}, wr_enable, 0);
        check({tag, " wr_zero"}, wr_zero, 0);
        check({tag, " wr_address"}, wr_address, 0);
        check({tag, " coeffaddress"}, coeffaddress, 0);
        check({tag, " sampleaddress"}, sampleaddress, 0);
        check({tag, " mac_enable"}, mac_enable, 0);
        check({tag, " mac_clear"}, mac_clear, 0);
        check({tag, " mac_last"}, mac_last, 0);
        check({tag, " dout_load"}, dout_load, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " overrun"}, overrun, 0);
    endtask

    // Releases reset (caller is at a falling edge) and checks the clear sweep.
    task automatic do_init();
        reset = 1'b1;
        for (int c = 1; c <= NT; c++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("init c%0d wr_enable", c), wr_enable, 1);
            check($sformatf("init c%0d wr_zero", c), wr_zero, 1);
            check($sformatf("init c%0d wr_address", c), wr_address, c - 1);
            check($sformatf("init c%0d busy", c), busy, 1);
            check($sformatf("init c%0d mac_enable", c), mac_enable, 0);
        end
        @(posedge clock);
        @(negedge clock);
        check("idle busy", busy, 0);
        check("idle wr_enable", wr_enable, 0);
        check("idle wr_zero", wr_zero, 0);
        check("idle coeffaddress", coeffaddress, 0);
        check("idle sampleaddress", sampleaddress, 0);
        check("idle mac_enable", mac_enable, 0);
        check("idle mac_clear", mac_clear, 0);
        check("idle mac_last", mac_last, 0);
        check("idle dout_load", dout_load, 0);
        check("idle overrun", overrun, 0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("gap busy", busy, 0);
            check("gap wr_enable", wr_enable, 0);
            check("gap mac_enable", mac_enable, 0);
            check("gap dout_load", dout_load, 0);
            check("gap coeffaddress", coeffaddress, m_coeff_hold);
            check("gap overrun", overrun, m_ov);
        end
    endtask

    // One sample from an IDLE falling edge; ov_cyc>0 pulses din_enable in that
    // cycle, abort_cyc>0 asserts reset in that cycle instead of completing.
    task automatic run_sample(input int ov_cyc, input int abort_cyc);
        int cur;
        int exp_coeff, exp_sample, exp_ov;
        cur = m_head;
        din_enable = 1'b1;
        for (int c = 1; c <= SPAN; c++) begin
            @(posedge clock);
            @(negedge clock);
            din_enable = (c == ov_cyc);
            if (c == 1) begin
                exp_coeff  = m_coeff_hold;
                exp_sample = m_sample_hold;
            end else if (c <= NT + 1) begin
                exp_coeff  = c - 2;
                exp_sample = wrap(cur - (c - 2));
            end else begin
                exp_coeff  = NT - 1;
                exp_sample = wrap(cur - (NT - 1));
            end
            exp_ov = (m_ov != 0 || (ov_cyc > 0 && c > ov_cyc)) ? 1 : 0;
            check($sformatf("cur%0d c%0d wr_enable", cur, c), wr_enable, (c == 1));
            check($sformatf("cur%0d c%0d wr_zero", cur, c), wr_zero, 0);
            check($sformatf("cur%0d c%0d wr_address", cur, c), wr_address, cur);
            check($sformatf("cur%0d c%0d coeffaddress", cur, c), coeffaddress, exp_coeff);
            check($sformatf("cur%0d c%0d sampleaddress", cur, c), sampleaddress, exp_sample);
            check($sformatf("cur%0d c%0d mac_enable", cur, c), mac_enable,
                  (c >= 2 + LAT && c <= NT + 1 + LAT));
            check($sformatf("cur%0d c%0d mac_clear", cur, c), mac_clear, (c == 2 + LAT));
            check($sformatf("cur%0d c%0d mac_last", cur, c), mac_last, (c == NT + 1 + LAT));
            check($sformatf("cur%0d c%0d dout_load", cur, c), dout_load, (c == NT + LAT + 2));
            check($sformatf("cur%0d c%0d busy", cur, c), busy, (c <= NT + LAT + 2));
            check($sformatf("cur%0d c%0d overrun", cur, c), overrun, exp_ov);
            if (c == abort_cyc) begin
                din_enable = 1'b0;
                reset = 1'b0;
                #1;
                check_all_zero("abort");
                return;
            end
        end
        m_head        = wrap(m_head + 1);
        m_coeff_hold  = NT - 1;
        m_sample_hold = wrap(cur - (NT - 1));
        if (ov_cyc >= 1 && ov_cyc < SPAN) m_ov = 1;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        do_init();

        // head=0 sample, then one accepted in the first IDLE cycle
        run_sample(0, 0);
        run_sample(0, 0);
        for (int s = 0; s < 8; s++) begin
            idle($urandom_range(0, 3));
            run_sample(0, 0);
        end

        idle(2);
        run_sample(30, 0);

        // carries head through 63 -> 0 and the second-lap cur=5 sample
        for (int s = 0; s < 60; s++) begin
            idle($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) run_sample($urandom_range(1, SPAN - 1), 0);
            else run_sample(0, 0);
        end

        idle(1);
        run_sample(0, 40);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            @(negedge clock);
            check("in reset dout_load", dout_load, 0);
            check("in reset busy", busy, 0);
            check("in reset wr_enable", wr_enable, 0);
        end
        m_head        = 0;
        m_ov          = 0;
        m_coeff_hold  = 0;
        m_sample_hold = 0;
        do_init();

        // din_enable during LOAD is an overrun
        run_sample(SPAN - 1, 0);
        idle(1);
        run_sample(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
